// File: rtl/calc_display_pkg.sv
// Shared types and constants for the calculator result display.
// Holds the symbol set, FSM states, segment patterns and the BCD adjust helper.
package calc_display_pkg;

    typedef enum logic [4:0] {
        SYM_0     = 5'd0,
        SYM_1     = 5'd1,
        SYM_2     = 5'd2,
        SYM_3     = 5'd3,
        SYM_4     = 5'd4,
        SYM_5     = 5'd5,
        SYM_6     = 5'd6,
        SYM_7     = 5'd7,
        SYM_8     = 5'd8,
        SYM_9     = 5'd9,
        SYM_A     = 5'd10,
        SYM_B     = 5'd11,
        SYM_C     = 5'd12,
        SYM_D     = 5'd13,
        SYM_E     = 5'd14,
        SYM_F     = 5'd15,
        SYM_BLANK = 5'd16,
        SYM_MINUS = 5'd17,
        SYM_H     = 5'd18
    } symbol_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } disp_state_t;

    // Active-low patterns ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [2:0] SHIFT_LAST = 3'd5;

    function automatic logic [7:0] bcd_adjust(input logic [7:0] bcd);
        logic [7:0] res;
        res[3:0] = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
        res[7:4] = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
        return res;
    endfunction

    function automatic symbol_t nibble_sym(input logic [3:0] nib);
        return symbol_t'({1'b0, nib});
    endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Maps one display symbol to its active-low seven-segment pattern.
module seg7_encoder
    import calc_display_pkg::*;
(
    input  logic [4:0] sym,
    output logic [6:0] seg
);

    // Symbol lookup; unknown codes fall back to a dark digit
    always_comb begin
        seg = SEG_BLANK;
        case (symbol_t'(sym))
            SYM_0:     seg = SEG_0;
            SYM_1:     seg = SEG_1;
            SYM_2:     seg = SEG_2;
            SYM_3:     seg = SEG_3;
            SYM_4:     seg = SEG_4;
            SYM_5:     seg = SEG_5;
            SYM_6:     seg = SEG_6;
            SYM_7:     seg = SEG_7;
            SYM_8:     seg = SEG_8;
            SYM_9:     seg = SEG_9;
            SYM_A:     seg = SEG_A;
            SYM_B:     seg = SEG_B;
            SYM_C:     seg = SEG_C;
            SYM_D:     seg = SEG_D;
            SYM_E:     seg = SEG_E;
            SYM_F:     seg = SEG_F;
            SYM_BLANK: seg = SEG_BLANK;
            SYM_MINUS: seg = SEG_MINUS;
            SYM_H:     seg = SEG_H;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display_driver.sv
// Converts the signed operand result to decimal or hex digits and scans them
// onto a 4-digit multiplexed active-low seven-segment display.
module result_display_driver
    import calc_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int MAG_W       = 6
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [MAG_W-1:0] display_result,
    input  logic             display_mode,
    output logic [6:0]       seg,
    output logic             dp,
    output logic [3:0]       an,
    output logic             busy
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    disp_state_t      state_r;
    logic [MAG_W-1:0] snap_val_r;
    logic             snap_mode_r;
    logic             init_pending_r;
    logic             neg_r;
    logic [MAG_W-1:0] mag_r;
    logic [7:0]       bcd_r;
    logic [2:0]       cnt_r;
    logic             busy_r;
    symbol_t          digit_r [4];

    logic [DIV_W-1:0] div_r;
    logic [1:0]       scan_idx_r;
    logic [3:0]       an_r;
    logic [6:0]       seg_r;
    logic             dp_r;

    logic [7:0]       bcd_adj_s;
    logic             input_changed_s;
    symbol_t          scan_sym_s;
    logic [6:0]       seg_pat_s;

    assign bcd_adj_s       = bcd_adjust(bcd_r);
    assign input_changed_s = ({display_result, display_mode} != {snap_val_r, snap_mode_r});

    // Conversion FSM: snapshot, double-dabble, then commit all four digits at once
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            snap_val_r     <= '0;
            snap_mode_r    <= 1'b0;
            init_pending_r <= 1'b1;
            neg_r          <= 1'b0;
            mag_r          <= '0;
            bcd_r          <= 8'd0;
            cnt_r          <= 3'd0;
            busy_r         <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                digit_r[i] <= SYM_BLANK;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (input_changed_s || init_pending_r) begin
                        snap_val_r     <= display_result;
                        snap_mode_r    <= display_mode;
                        init_pending_r <= 1'b0;
                        busy_r         <= 1'b1;
                        state_r        <= ST_LOAD;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    // Magnitude of -32 wraps to 6'b100000, which reads correctly as unsigned 32
                    neg_r   <= snap_val_r[MAG_W-1];
                    mag_r   <= snap_val_r[MAG_W-1] ? (~snap_val_r + MAG_W'(1)) : snap_val_r;
                    bcd_r   <= 8'd0;
                    cnt_r   <= 3'd0;
                    state_r <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    {bcd_r, mag_r} <= {bcd_adj_s, mag_r} << 1'b1;
                    cnt_r          <= cnt_r + 3'd1;
                    if (cnt_r == SHIFT_LAST) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    if (snap_mode_r) begin
                        digit_r[3] <= SYM_H;
                        digit_r[2] <= SYM_BLANK;
                        digit_r[1] <= nibble_sym({2'b00, snap_val_r[5:4]});
                        digit_r[0] <= nibble_sym(snap_val_r[3:0]);
                    end else begin
                        digit_r[3] <= SYM_BLANK;
                        digit_r[0] <= nibble_sym(bcd_r[3:0]);
                        if (bcd_r[7:4] != 4'd0) begin
                            digit_r[2] <= neg_r ? SYM_MINUS : SYM_BLANK;
                            digit_r[1] <= nibble_sym(bcd_r[7:4]);
                        end else begin
                            digit_r[2] <= SYM_BLANK;
                            digit_r[1] <= neg_r ? SYM_MINUS : SYM_BLANK;
                        end
                    end
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Refresh divider and digit scan index
    always_ff @(posedge clk) begin
        if (reset) begin
            div_r      <= '0;
            scan_idx_r <= 2'd0;
        end else if (div_r == DIV_LAST) begin
            div_r      <= '0;
            scan_idx_r <= scan_idx_r + 2'd1;
        end else begin
            div_r      <= div_r + DIV_W'(1);
            scan_idx_r <= scan_idx_r;
        end
    end

    assign scan_sym_s = digit_r[scan_idx_r];

    seg7_encoder u_seg7_encoder (
        .sym (scan_sym_s),
        .seg (seg_pat_s)
    );

    // Registered display outputs, one cycle behind the scan index
    always_ff @(posedge clk) begin
        if (reset) begin
            an_r  <= 4'hF;
            seg_r <= SEG_BLANK;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= ~(4'b0001 << scan_idx_r);
            seg_r <= seg_pat_s;
            dp_r  <= 1'b1;
        end
    end

    assign seg  = seg_r;
    assign an   = an_r;
    assign dp   = dp_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_result_display_driver.sv
// Directed plus random bench for result_display_driver, checked against a
// digit-level model built from integer arithmetic on the shown value.
module tb_result_display_driver;

    typedef logic [3:0][6:0] disp_t;

    localparam logic [6:0] S_BLANK = 7'b1111111;
    localparam logic [6:0] S_MINUS = 7'b0111111;
    localparam logic [6:0] S_H     = 7'b0001001;

    logic [6:0] hex_tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] display_result;
    logic       display_mode;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       busy;

    int    checks = 0;
    int    errors = 0;
    disp_t cur;
    disp_t blank;

    always #5 clk = ~clk;

    result_display_driver #(.REFRESH_DIV(4), .MAG_W(6)) dut (
        .clk            (clk),
        .reset          (reset),
        .display_result (display_result),
        .display_mode   (display_mode),
        .seg            (seg),
        .dp             (dp),
        .an             (an),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected pattern per digit position, d3..d0
    function automatic disp_t model(input logic [5:0] v, input logic m);
        disp_t d;
        int s, a, tens, units;
        d = {4{S_BLANK}};
        if (m) begin
            d[3] = S_H;
            d[1] = hex_tbl[{2'b00, v[5:4]}];
            d[0] = hex_tbl[v[3:0]];
        end else begin
            s     = int'($signed(v));
            a     = (s < 0) ? -s : s;
            tens  = a / 10;
            units = a % 10;
            d[0]  = hex_tbl[units];
            if (tens != 0) begin
                d[1] = hex_tbl[tens];
                if (s < 0) d[2] = S_MINUS;
            end else if (s < 0) begin
                d[1] = S_MINUS;
            end
        end
        return d;
    endfunction

    function automatic int an_pos(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic scan_check(input string tag, input disp_t exp);
        logic [3:0] seen;
        int pos;
        seen = 4'b0000;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            pos = an_pos(an);
            if (pos >= 0) begin
                chk($sformatf("%s d%0d", tag, pos), seg, exp[pos]);
                seen[pos] = 1'b1;
            end
        end
        chk({tag, " scan"}, seen, 4'hF);
        chk({tag, " dp"}, dp, 1'b1);
    endtask

    // Inputs (or reset release) already applied at the current negedge
    task automatic convert(input string tag, input disp_t old_d, input disp_t new_d,
                           input bit do_scan, input int chg_at,
                           input logic [5:0] chg_v, input logic chg_m);
        int n;
        int pos;
        @(posedge clk);
        @(negedge clk);
        chk({tag, " busy rise"}, busy, 1'b1);
        n = 0;
        while (busy === 1'b1 && n < 30) begin
            n++;
            pos = an_pos(an);
            if (pos >= 0) chk($sformatf("%s old d%0d", tag, pos), seg, old_d[pos]);
            if (n == chg_at) begin
                display_result = chg_v;
                display_mode   = chg_m;
            end
            @(negedge clk);
        end
        chk({tag, " busy len"}, n, 8);
        if (do_scan) begin
            @(negedge clk);
            scan_check(tag, new_d);
        end
    endtask

    task automatic step(input string tag, input logic [5:0] v, input logic m);
        disp_t nxt;
        display_result = v;
        display_mode   = m;
        nxt = model(v, m);
        convert(tag, cur, nxt, 1'b1, 0, 6'd0, 1'b0);
        cur = nxt;
    endtask

    initial begin
        logic [5:0] rv;
        logic       rm;
        reset          = 1'b1;
        display_result = 6'd0;
        display_mode   = 1'b0;
        blank          = {4{S_BLANK}};
        repeat (3) @(negedge clk);
        chk("rst an", an, 4'hF);
        chk("rst seg", seg, 7'h7F);
        chk("rst busy", busy, 1'b0);
        chk("rst dp", dp, 1'b1);
        reset = 1'b0;
        cur = model(6'd0, 1'b0);
        convert("init", blank, cur, 1'b1, 0, 6'd0, 1'b0);

        step("m32", 6'b100000, 1'b0);
        step("m5",  6'b111011, 1'b0);
        step("p31", 6'd31, 1'b0);
        step("p9",  6'd9, 1'b0);
        step("h3F", 6'b111111, 1'b1);
        step("h15", 6'b010101, 1'b1);

        // +12 arrives 3 cycles into the +7 conversion
        display_result = 6'd7;
        display_mode   = 1'b0;
        convert("mid7", cur, model(6'd7, 1'b0), 1'b0, 3, 6'd12, 1'b0);
        cur = model(6'd7, 1'b0);
        convert("mid12", cur, model(6'd12, 1'b0), 1'b1, 0, 6'd0, 1'b0);
        cur = model(6'd12, 1'b0);

        // One-cycle reset while the -20 conversion is shifting
        display_result = 6'b101100;
        @(posedge clk);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst busy", busy, 1'b0);
        chk("midrst an", an, 4'hF);
        chk("midrst seg", seg, 7'h7F);
        reset = 1'b0;
        cur = model(6'b101100, 1'b0);
        convert("rst20", blank, cur, 1'b1, 0, 6'd0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            rv = 6'($urandom_range(0, 63));
            rm = 1'($urandom_range(0, 1));
            if ({rv, rm} == {display_result, display_mode}) rm = ~rm;
            step($sformatf("rnd%0d", i), rv, rm);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
